// File: rtl/spi_debug_tx_master_if.sv
// Byte-stream input handshake plus Avalon-MM master port toward the JTAG UART.
interface spi_debug_tx_master_if;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned AVM_DW = 32;

  logic [BYTE_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              avm_address;
  logic              avm_chipselect;
  logic              avm_read_n;
  logic              avm_write_n;
  logic [AVM_DW-1:0] avm_writedata;
  logic [AVM_DW-1:0] avm_readdata;
  logic              avm_waitrequest;

  modport master (
    input  in_data, in_valid, avm_readdata, avm_waitrequest,
    output in_ready, avm_address, avm_chipselect, avm_read_n, avm_write_n, avm_writedata
  );

  modport slave (
    output in_data, in_valid, avm_readdata, avm_waitrequest,
    input  in_ready, avm_address, avm_chipselect, avm_read_n, avm_write_n, avm_writedata
  );
endinterface

// File: rtl/spi_debug_tx_master.sv
// Buffers debug bytes and forwards them to a JTAG UART over Avalon-MM, polling for space.
// Define SPI_DEBUG_HEX_EN to emit each byte as two uppercase hex digits plus a space.
module spi_debug_tx_master (
  input  logic                          clk,
  input  logic                          rst_n,
  spi_debug_tx_master_if.master         bus,
  output logic                          busy_o,
  output logic [15:0]                   bytes_sent_o
);
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned PTR_W   = 4;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned SPACE_W = 7;
  localparam int unsigned SENT_W  = 16;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned AVM_DW  = 32;

  typedef enum logic [1:0] {IDLE, POLL, WRITE} state_e;

  state_e              state_q;
  logic [BYTE_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [SPACE_W-1:0]  space_q;
  logic [SENT_W-1:0]   bytes_sent_q;
  logic                in_ready_q, busy_q, busy_d;
  logic                cs_q, read_n_q, write_n_q, addr_q;
  logic [AVM_DW-1:0]   wdata_q;
  logic                push, pop, done, last_char;
  logic [BYTE_W-1:0]   head, cur_char;
  logic                unused_rd;

  assign head      = mem_q[rd_ptr_q];
  assign push      = bus.in_valid & in_ready_q;
  assign done      = (state_q == WRITE) & ~bus.avm_waitrequest;
  assign pop       = done & last_char;
  assign count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
  assign busy_d    = (count_d != '0) || ((state_q != IDLE) && bus.avm_waitrequest);
  assign unused_rd = ^{bus.avm_readdata[31:23], bus.avm_readdata[15:0]};

`ifdef SPI_DEBUG_HEX_EN
  logic [1:0] char_idx_q;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + 8'(nib)) : (8'h37 + 8'(nib));
  endfunction

  // Character index survives any polls taken between the three characters of a byte.
  always_comb begin
    cur_char = 8'h20;
    case (char_idx_q)
      2'd0:    cur_char = hex_ascii(head[7:4]);
      2'd1:    cur_char = hex_ascii(head[3:0]);
      default: cur_char = 8'h20;
    endcase
  end

  assign last_char = (char_idx_q == 2'd2);

  always_ff @(posedge clk) begin
    if (!rst_n)    char_idx_q <= '0;
    else if (done) char_idx_q <= last_char ? 2'd0 : (char_idx_q + 2'd1);
  end
`else
  assign cur_char  = head;
  assign last_char = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q    <= count_d;
      in_ready_q <= (count_d != CNT_W'(DEPTH));
      busy_q     <= busy_d;
    end
  end

  // Strobes are set on entry to POLL/WRITE and held untouched until the slave releases waitrequest.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      space_q      <= '0;
      bytes_sent_q <= '0;
      cs_q         <= 1'b0;
      read_n_q     <= 1'b1;
      write_n_q    <= 1'b1;
      addr_q       <= 1'b0;
      wdata_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (count_q != '0) begin
            cs_q <= 1'b1;
            if (space_q == '0) begin
              state_q  <= POLL;
              read_n_q <= 1'b0;
              addr_q   <= 1'b1;
            end else begin
              state_q   <= WRITE;
              write_n_q <= 1'b0;
              addr_q    <= 1'b0;
              wdata_q   <= {24'h0, cur_char};
            end
          end
        end
        POLL: begin
          if (!bus.avm_waitrequest) begin
            space_q  <= bus.avm_readdata[22:16];
            state_q  <= IDLE;
            cs_q     <= 1'b0;
            read_n_q <= 1'b1;
          end
        end
        WRITE: begin
          if (!bus.avm_waitrequest) begin
            space_q   <= space_q - SPACE_W'(1);
            state_q   <= IDLE;
            cs_q      <= 1'b0;
            write_n_q <= 1'b1;
            if (last_char) bytes_sent_q <= bytes_sent_q + SENT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready       = in_ready_q;
  assign bus.avm_address    = addr_q;
  assign bus.avm_chipselect = cs_q;
  assign bus.avm_read_n     = read_n_q;
  assign bus.avm_write_n    = write_n_q;
  assign bus.avm_writedata  = wdata_q;
  assign busy_o             = busy_q;
  assign bytes_sent_o       = bytes_sent_q;
endmodule

// File: tb/tb_spi_debug_tx_master.sv
// Directed bench for spi_debug_tx_master with a behavioural JTAG-UART-like Avalon slave.
module tb_spi_debug_tx_master;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy_o;
  logic [15:0] bytes_sent_o;

  spi_debug_tx_master_if bus ();

  spi_debug_tx_master dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .busy_o       (busy_o),
    .bytes_sent_o (bytes_sent_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave model: waitrequest high for stall_cycles of each access, space from poll_q (64 when empty).
  int          stall_cycles = 1;
  int          age = 0;
  logic [6:0]  poll_q [$];
  logic [6:0]  rd_space = 7'd64;
  logic [7:0]  wlog [$];
  logic [7:0]  exp_q [$];
  string       ev = "";
  int          slave_space = 0;
  int          overflow = 0;
  int          unstable = 0;
  int          bad_upper = 0;
  logic [31:0] held_wd;
  logic        held_addr;

  always @(negedge clk) rd_space = (poll_q.size() != 0) ? poll_q[0] : 7'd64;

  assign bus.avm_readdata    = {9'h0, rd_space, 16'h0};
  assign bus.avm_waitrequest = !(bus.avm_chipselect && (age >= stall_cycles));

  always @(posedge clk) begin
    if (!rst_n || !bus.avm_chipselect) begin
      age <= 0;
    end else if (bus.avm_waitrequest) begin
      if (age > 0 && (bus.avm_writedata !== held_wd || bus.avm_address !== held_addr)) unstable++;
      held_wd   = bus.avm_writedata;
      held_addr = bus.avm_address;
      age <= age + 1;
    end else begin
      age <= 0;
      if (!bus.avm_write_n) begin
        wlog.push_back(bus.avm_writedata[7:0]);
        ev = {ev, "W"};
        if (bus.avm_writedata[31:8] != 24'h0) bad_upper++;
        if (slave_space <= 0) overflow++;
        else slave_space--;
      end
      if (!bus.avm_read_n) begin
        ev = {ev, "P"};
        slave_space = int'(rd_space);
        if (poll_q.size() != 0) void'(poll_q.pop_front());
      end
    end
  end

`ifdef SPI_DEBUG_HEX_EN
  localparam int CPB = 3;
`else
  localparam int CPB = 1;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_str(input string tag, input string obs, input string exp);
    n_checks++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed \"%s\" expected \"%s\"", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] asc(input logic [3:0] n);
    return (n <= 4'd9) ? (8'd48 + 8'(n)) : (8'd65 + 8'(n) - 8'd10);
  endfunction

  task automatic add_exp(input logic [7:0] b);
`ifdef SPI_DEBUG_HEX_EN
    exp_q.push_back(asc(b[7:4]));
    exp_q.push_back(asc(b[3:0]));
    exp_q.push_back(8'h20);
`else
    exp_q.push_back(b);
`endif
  endtask

  task automatic check_log(input string tag);
    check({tag, "_wcount"}, 32'(wlog.size()), 32'(exp_q.size()));
    for (int i = 0; i < wlog.size() && i < exp_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), 32'(wlog[i]), 32'(exp_q[i]));
  endtask

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic push(input logic [7:0] b);
    int g = 0;
    while (!bus.in_ready && g < 500) begin @(negedge clk); g++; end
    if (g >= 500) check("push_timeout", 32'(bus.in_ready), 32'd1);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int g = 0;
    while (busy_o && g < budget) begin @(negedge clk); g++; end
    check({tag, "_idle"}, 32'(busy_o), 32'd0);
  endtask

  task automatic wait_write(input string tag, input int budget);
    int g = 0;
    while (bus.avm_write_n && g < budget) begin @(negedge clk); g++; end
    check({tag, "_wstart"}, 32'(bus.avm_write_n), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    poll_q.delete();
    wlog.delete();
    exp_q.delete();
    ev           = "";
    slave_space  = 0;
    overflow     = 0;
    unstable     = 0;
    bad_upper    = 0;
    stall_cycles = 1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int g;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_cs",      32'(bus.avm_chipselect), 32'd0);
    check("rst_read_n",  32'(bus.avm_read_n),     32'd1);
    check("rst_write_n", 32'(bus.avm_write_n),    32'd1);
    check("rst_addr",    32'(bus.avm_address),    32'd0);
    check("rst_wdata",   bus.avm_writedata,       32'd0);
    check("rst_ready",   32'(bus.in_ready),       32'd0);
    check("rst_busy",    32'(busy_o),             32'd0);
    check("rst_sent",    32'(bytes_sent_o),       32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(bus.in_ready), 32'd1);

    // Single byte: one poll returning 64, then the write(s)
    poll_q.push_back(7'd64);
    push(8'h41);
    wait_idle("single", 100);
    add_exp(8'h41);
    check_log("single");
`ifdef SPI_DEBUG_HEX_EN
    check_str("single_ev", ev, "PWWW");
`else
    check_str("single_ev", ev, "PW");
`endif
    check("single_sent", 32'(bytes_sent_o), 32'd1);
    check("single_upper", 32'(bad_upper), 32'd0);

    // 20 bytes back-to-back with the first poll stalled so the FIFO fills
    do_reset();
    poll_q.push_back(7'd5);
    poll_q.push_back(7'd0);
    poll_q.push_back(7'd0);
    poll_q.push_back(7'd64);
    stall_cycles = 40;
    for (int i = 0; i < 16; i++) begin
      push(8'(i * 13 + 7));
      add_exp(8'(i * 13 + 7));
    end
    check("full_ready", 32'(bus.in_ready), 32'd0);
    check("full_busy",  32'(busy_o),       32'd1);
    stall_cycles = 1;
    for (int i = 16; i < 20; i++) begin
      push(8'(i * 13 + 7));
      add_exp(8'(i * 13 + 7));
    end
    wait_idle("burst", 3000);
    check_log("burst");
    check("burst_sent",     32'(bytes_sent_o), 32'd20);
    check("burst_overflow", 32'(overflow),     32'd0);

    // Polls return 0 three times, then 2, then 1
    do_reset();
    poll_q.push_back(7'd0);
    poll_q.push_back(7'd0);
    poll_q.push_back(7'd0);
    poll_q.push_back(7'd2);
    poll_q.push_back(7'd1);
    push(8'h10); add_exp(8'h10);
    push(8'h20); add_exp(8'h20);
    push(8'h30); add_exp(8'h30);
    wait_idle("repoll", 500);
`ifdef SPI_DEBUG_HEX_EN
    check_str("repoll_ev", ev, "PPPPWWPWPWWWWWW");
`else
    check_str("repoll_ev", ev, "PPPPWWPW");
`endif
    check_log("repoll");
    check("repoll_sent",     32'(bytes_sent_o), 32'd3);
    check("repoll_overflow", 32'(overflow),     32'd0);

    // Write held off by waitrequest for 5 cycles
    do_reset();
    poll_q.push_back(7'd64);
    stall_cycles = 5;
    push(8'h5A);
    add_exp(8'h5A);
    wait_write("stall", 100);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("stall_wdata%0d", k), bus.avm_writedata, {24'h0, exp_q[0]});
      check($sformatf("stall_addr%0d", k),  32'(bus.avm_address), 32'd0);
      check($sformatf("stall_sent%0d", k),  32'(bytes_sent_o), 32'd0);
      @(negedge clk);
    end
    wait_idle("stall", 200);
    check("stall_unstable", 32'(unstable), 32'd0);
    check_log("stall");
    check("stall_sent", 32'(bytes_sent_o), 32'd1);

    // Character encoding of 0x3C and 0xAF; count only moves after the last character
    do_reset();
    poll_q.push_back(7'd64);
    push(8'h3C);
    push(8'hAF);
`ifdef SPI_DEBUG_HEX_EN
    g = 0;
    while (wlog.size() < 2 && g < 100) begin @(negedge clk); g++; end
    check("hex_two_chars", 32'(wlog.size()), 32'd2);
    check("hex_sent_mid",  32'(bytes_sent_o), 32'd0);
    exp_q.push_back(8'h33); exp_q.push_back(8'h43); exp_q.push_back(8'h20);
    exp_q.push_back(8'h41); exp_q.push_back(8'h46); exp_q.push_back(8'h20);
`else
    g = 0;
    exp_q.push_back(8'h3C); exp_q.push_back(8'hAF);
`endif
    wait_idle("enc", 200);
    check_log("enc");
    check("enc_sent", 32'(bytes_sent_o), 32'd2);

    // Reset in the middle of a write with bytes queued
    do_reset();
    poll_q.push_back(7'd64);
    for (int i = 1; i <= 5; i++) push(8'(i));
    wait_write("midrst", 100);
    g = wlog.size();
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_cs",      32'(bus.avm_chipselect), 32'd0);
    check("midrst_write_n", 32'(bus.avm_write_n),    32'd1);
    check("midrst_read_n",  32'(bus.avm_read_n),     32'd1);
    check("midrst_busy",    32'(busy_o),             32'd0);
    check("midrst_sent",    32'(bytes_sent_o),       32'd0);
    check("midrst_ready",   32'(bus.in_ready),       32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_after_busy",  32'(busy_o),       32'd0);
    check("midrst_after_log",   32'(wlog.size()),  32'(g));
    check("midrst_after_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_after_sent",  32'(bytes_sent_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_debug_tx_master.md
SPI_DEBUG_TX_MASTER -- requirements
Module: spi_debug_tx_master

Interface
REQ-001 SHALL use one clock and a synchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, synchronous active-low reset.
REQ-002 SHALL provide in_data, input, 8 bits: byte to be forwarded to the JTAG UART.
REQ-003 SHALL provide in_valid, input, 1 bit: in_data is valid.
REQ-004 SHALL provide in_ready, output, 1 bit: byte is accepted on the clk edge where in_valid & in_ready.
REQ-005 SHALL provide avm_address, output, 1 bit: 0 selects the data register, 1 selects the control register.
REQ-006 SHALL provide avm_chipselect, output, 1 bit: active-high slave select.
REQ-007 SHALL provide avm_read_n, output, 1 bit: active-low read strobe.
REQ-008 SHALL provide avm_write_n, output, 1 bit: active-low write strobe.
REQ-009 SHALL provide avm_writedata, output, 32 bits: write payload, bits [31:8] always 0.
REQ-010 SHALL provide avm_readdata, input, 32 bits: slave read data, valid in the cycle avm_waitrequest is low.
REQ-011 SHALL provide avm_waitrequest, input, 1 bit: slave stall; the access completes in the cycle it is low while the request is held.
REQ-012 SHALL provide busy, output, 1 bit: FIFO non-empty or FSM not in IDLE.
REQ-013 SHALL provide bytes_sent, output, 16 bits: count of input bytes fully written; wraps 0xFFFF->0x0000.

Function
REQ-014 SHALL buffer input bytes in a 16-entry FIFO; in_ready = ~full; a push with in_valid while full is impossible by construction.
REQ-015 SHALL hold a 7-bit space counter (range 0..64) tracking write space known free in the slave.
REQ-016 SHALL implement FSM states IDLE, POLL, WRITE; all avm_* outputs SHALL be registered.
REQ-017 In IDLE with the FIFO empty, SHALL remain in IDLE; with the FIFO non-empty and space==0, SHALL go to POLL; with the FIFO non-empty and space>0, SHALL go to WRITE.
REQ-018 In POLL, SHALL drive chipselect=1, read_n=0, address=1 until waitrequest=0, then load space<=avm_readdata[22:16] and return to IDLE.
REQ-019 In WRITE, SHALL drive chipselect=1, write_n=0, address=0, writedata={24'h0, char} until waitrequest=0, then decrement space and return to IDLE.
REQ-020 In IDLE, SHALL deassert all strobes (chipselect=0, read_n=1, write_n=1).
REQ-021 Minimum cost per write SHALL be 3 cycles: request, completion, IDLE.
REQ-022 If a poll returns 0, SHALL re-poll via IDLE with no limit.
REQ-023 SHALL never issue a write while space==0, so the slave woverflow never sets.
REQ-024 SHALL pop the FIFO head and increment bytes_sent in the cycle the last character of that byte completes.
REQ-025 A FIFO push and pop in the same cycle SHALL leave the count unchanged; a byte pushed into an empty FIFO SHALL be visible to IDLE on the next cycle.
REQ-026 SHALL never change writedata or address while a request is stalled.

Reset
REQ-027 On a clk edge with rst_n=0, SHALL set FSM=IDLE, FIFO empty, space=0, bytes_sent=0, chipselect=0, read_n=1, write_n=1, address=0, writedata=0, in_ready=0, busy=0.
REQ-028 Reset mid-transaction SHALL abandon the access and drop the FIFO contents.
REQ-029 in_ready SHALL go to 1 on the first cycle after rst_n=1.

Configuration
REQ-030 With macro SPI_DEBUG_HEX_EN defined, each byte SHALL be emitted as three writes: ASCII high nibble, ASCII low nibble (uppercase '0'-'9','A'-'F'), then 0x20.
REQ-031 In hex mode, space SHALL be checked before each character; a poll may occur mid-byte, and the character index SHALL be preserved across the poll.
REQ-032 With SPI_DEBUG_HEX_EN undefined, each byte SHALL be written raw as a single write.

Verification
REQ-033 Reset, push 0x41, slave poll returns readdata[22:16]=64 -> one POLL then one write of 0x00000041; bytes_sent=1; busy=0 afterwards.
REQ-034 Push 20 bytes back-to-back -> in_ready low after 16 are buffered; all 20 written in order; no write when space=0.
REQ-035 Poll returns 0 three times, then 2, with 3 bytes queued -> 4 polls, 2 writes, 1 poll, 1 write.
REQ-036 Slave holds waitrequest high for 5 cycles during a write -> writedata/address stable; exactly one write counted.
REQ-037 With HEX_EN, push 0x3C -> writes 0x33, 0x43, 0x20; bytes_sent increments only after 0x20.
REQ-038 rst_n=0 mid-write with 5 bytes queued -> strobes inactive on the next cycle; FIFO empty; bytes_sent=0.
